exec_control: RTL and testbench

Execute stage and control FSM that sits directly downstream of the instruction memory. Consumes the 10-bit instruction word {op[3:0], rx[2:0], ry[2:0]} from the memory's combinational output, sequences LOAD/MOVE/ADD/XOR/BR over an internal six-entry 8-bit register file, and drives the memory's `done` (PC advance) and `branch`/`branchaddress` (PC load) inputs.

---
 rtl/exec_control_if.sv | 19 +
 rtl/exec_control.sv | 152 +++++++++++++++
 tb/tb_exec_control.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_control_if.sv
`default_nettype none
// ============================================================
// Module   : exec_control_if
// Desc     : instruction-memory link: instruction in, PC advance/load out
// Revision : 1.0
// ============================================================
interface exec_control_if #(
  parameter int INSTR_W = 10,
  parameter int BA_W    = 4
) ();
  logic [INSTR_W-1:0] instruction;
  logic               done;
  logic               branch;
  logic [BA_W-1:0]    branchaddress;

  modport master (input instruction, output done, branch, branchaddress);
  modport slave  (output instruction, input done, branch, branchaddress);
endinterface
`default_nettype wire

// File: rtl/exec_control.sv
`default_nettype none
// ============================================================
// Module   : exec_control
// Desc     : execute stage + control FSM; EXEC_BRZ_EN enables BRZ (op 1001)
// Revision : 1.0
// ============================================================
module exec_control #(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ARG_NUM  = 2,
  parameter int DATA_W   = 8
) (
  input  wire                 clk,
  input  wire                 rst,
  input  wire                 run,
  input  wire  [DATA_W-1:0]   din,
  input  wire  [ARG_SIZE-1:0] dbg_sel,
  exec_control_if.master      imem,
  output logic                busy,
  output logic                zero,
  output logic [DATA_W-1:0]   dbg_data
);
  localparam int INSTR_W  = OP_SIZE + ARG_NUM * ARG_SIZE;
  localparam int BA_W     = 4;
  localparam int NUM_REGS = 6;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_ALU    = 3'd3;
  localparam logic [2:0] S_RETIRE = 3'd4;

  localparam logic [OP_SIZE-1:0] OP_LOAD = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_MOVE = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_BR   = OP_SIZE'(8);
`ifdef EXEC_BRZ_EN
  localparam logic [OP_SIZE-1:0] OP_BRZ  = OP_SIZE'(9);
`endif

  logic [2:0]          state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   t_q, t_d;
  logic                zero_q, zero_d;
  logic [DATA_W-1:0]   regs_q [1:NUM_REGS];
  logic [DATA_W-1:0]   regs_d [1:NUM_REGS];

  logic [OP_SIZE-1:0]  op;
  logic [ARG_SIZE-1:0] rx, ry;
  logic                take_branch;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   alu_res;

  assign op = ir_q[INSTR_W-1 -: OP_SIZE];
  assign rx = ir_q[ARG_SIZE +: ARG_SIZE];
  assign ry = ir_q[0 +: ARG_SIZE];

  // Index 0 (NA) and 7 (PC) have no storage and read as zero.
  function automatic logic [DATA_W-1:0] read_reg(input logic [ARG_SIZE-1:0] idx);
    read_reg = '0;
    for (int i = 1; i <= NUM_REGS; i++) begin
      if (idx == ARG_SIZE'(i)) read_reg = regs_q[i];
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q   <= '0;
      t_q    <= '0;
      zero_q <= 1'b0;
      for (int i = 1; i <= NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ir_q   <= ir_d;
      t_q    <= t_d;
      zero_q <= zero_d;
      for (int i = 1; i <= NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    take_branch = 1'b0;
    if (state_q == S_EXEC) begin
      if (op == OP_BR) take_branch = 1'b1;
`ifdef EXEC_BRZ_EN
      else if (op == OP_BRZ && zero_q) take_branch = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = run ? S_DECODE : S_IDLE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (take_branch)                      state_d = run ? S_DECODE : S_IDLE;
        else if (op == OP_ADD || op == OP_XOR) state_d = S_ALU;
        else                                  state_d = S_RETIRE;
      end
      S_ALU:    state_d = S_RETIRE;
      S_RETIRE: state_d = run ? S_DECODE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ir_d    = ir_q;
    t_d     = t_q;
    zero_d  = zero_q;
    regs_d  = regs_q;
    wr_en   = 1'b0;
    wr_data = '0;
    alu_res = (op == OP_ADD) ? (t_q + read_reg(ry)) : (t_q ^ read_reg(ry));
    case (state_q)
      S_DECODE: ir_d = imem.instruction;
      S_EXEC: begin
        case (op)
          OP_LOAD: begin wr_en = 1'b1; wr_data = din;          end
          OP_MOVE: begin wr_en = 1'b1; wr_data = read_reg(ry); end
          OP_ADD, OP_XOR: t_d = read_reg(rx);
          default: ;
        endcase
      end
      S_ALU: begin
        wr_en   = 1'b1;
        wr_data = alu_res;
        zero_d  = (alu_res == '0);
      end
      default: ;
    endcase
    for (int i = 1; i <= NUM_REGS; i++) begin
      if (wr_en && rx == ARG_SIZE'(i)) regs_d[i] = wr_data;
    end
  end

  always_comb begin
    busy               = (state_q != S_IDLE);
    imem.done          = (state_q == S_RETIRE);
    imem.branch        = take_branch;
    imem.branchaddress = take_branch ? ir_q[BA_W-1:0] : '0;
    zero               = zero_q;
    dbg_data           = read_reg(dbg_sel);
  end
endmodule
`default_nettype wire

// File: tb/tb_exec_control.sv
`default_nettype none
// Directed bench for exec_control; a small program memory follows done/branch like the real PC.
module tb_exec_control;
  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       run     = 1'b0;
  logic [7:0] din     = '0;
  logic [2:0] dbg_sel = '0;
  logic       busy, zero;
  logic [7:0] dbg_data;

  logic [9:0]  prog [0:15];
  logic [3:0]  pc;
  int          passed = 0;
  int          total  = 0;
  logic [31:0] done_v, br_v;
  logic [3:0]  ba_seen;
  int          ba_bad;
  logic [7:0]  rv;

  exec_control_if ifc ();

  exec_control dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .din      (din),
    .dbg_sel  (dbg_sel),
    .imem     (ifc),
    .busy     (busy),
    .zero     (zero),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  assign ifc.instruction = prog[pc];

  always @(posedge clk or posedge rst) begin
    if (rst)             pc <= 4'd0;
    else if (ifc.done)   pc <= pc + 4'd1;
    else if (ifc.branch) pc <= ifc.branchaddress;
  end

  function automatic logic [9:0] enc(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {op, rx, ry};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] sel, output logic [7:0] val);
    dbg_sel = sel;
    #1;
    val = dbg_data;
  endtask

  // Raise run, step n cycles recording done/branch per cycle index, drop run after cycle drop_after.
  task automatic run_for(input int n, input int drop_after);
    done_v  = '0;
    br_v    = '0;
    ba_seen = '0;
    ba_bad  = 0;
    run     = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      done_v[i] = ifc.done;
      br_v[i]   = ifc.branch;
      if (ifc.branch) ba_seen = ifc.branchaddress;
      else if (ifc.branchaddress !== 4'd0) ba_bad++;
      if (i == drop_after) run = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    run = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (ifc.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", ifc.done); else passed++;
    total++; if (ifc.branch !== 1'b0) $display("FAIL reset_branch: got %b expected 0", ifc.branch); else passed++;
    total++; if (ifc.branchaddress !== 4'd0) $display("FAIL reset_ba: got %h expected 0", ifc.branchaddress); else passed++;
    total++; if (zero !== 1'b0) $display("FAIL reset_zero: got %b expected 0", zero); else passed++;
    for (int i = 1; i <= 6; i++) begin
      read_reg(3'(i), rv);
      total++; if (rv !== 8'h00) $display("FAIL reset_R%0d: got %h expected 00", i, rv); else passed++;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_program();
    do_reset();
    prog[0] = enc(4'd0, 3'd1, 3'd0);
    prog[1] = enc(4'd1, 3'd2, 3'd1);
    prog[2] = enc(4'd2, 3'd1, 3'd2);
    din = 8'h05;
    run_for(11, 10);
    total++; if (done_v !== 32'h0000_0448) $display("FAIL prog_done_timing: got %h expected 00000448", done_v); else passed++;
    total++; if (br_v !== 32'h0) $display("FAIL prog_no_branch: got %h expected 0", br_v); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL prog_idle: got busy %b expected 0", busy); else passed++;
    read_reg(3'd1, rv);
    total++; if (rv !== 8'h0A) $display("FAIL prog_R1: got %h expected 0a", rv); else passed++;
    read_reg(3'd2, rv);
    total++; if (rv !== 8'h05) $display("FAIL prog_R2: got %h expected 05", rv); else passed++;
    total++; if (zero !== 1'b0) $display("FAIL prog_zero: got %b expected 0", zero); else passed++;
  endtask

  task automatic test_add_wrap();
    do_reset();
    prog[0] = enc(4'd0, 3'd1, 3'd0);
    prog[1] = enc(4'd0, 3'd2, 3'd0);
    prog[2] = enc(4'd2, 3'd1, 3'd2);
    din = 8'hFF;
    run_for(4, 3);
    total++; if (done_v !== 32'h8) $display("FAIL load_latency: got %h expected 00000008", done_v); else passed++;
    din = 8'h01;
    run_for(4, 3);
    din = 8'h00;
    run_for(5, 4);
    total++; if (done_v !== 32'h10) $display("FAIL add_done_once: got %h expected 00000010", done_v); else passed++;
    read_reg(3'd1, rv);
    total++; if (rv !== 8'h00) $display("FAIL add_wrap_R1: got %h expected 00", rv); else passed++;
    read_reg(3'd2, rv);
    total++; if (rv !== 8'h01) $display("FAIL add_wrap_R2: got %h expected 01", rv); else passed++;
    total++; if (zero !== 1'b1) $display("FAIL add_wrap_zero: got %b expected 1", zero); else passed++;
  endtask

  task automatic test_xor_zero();
    do_reset();
    prog[0] = enc(4'd0, 3'd1, 3'd0);
    prog[1] = enc(4'd0, 3'd2, 3'd0);
    prog[2] = enc(4'd3, 3'd2, 3'd1);
    prog[3] = enc(4'd0, 3'd3, 3'd0);
    prog[4] = enc(4'd3, 3'd1, 3'd3);
    din = 8'h3C;
    run_for(4, 3);
    run_for(4, 3);
    run_for(5, 4);
    total++; if (done_v !== 32'h10) $display("FAIL xor_done: got %h expected 00000010", done_v); else passed++;
    read_reg(3'd2, rv);
    total++; if (rv !== 8'h00) $display("FAIL xor_R2: got %h expected 00", rv); else passed++;
    read_reg(3'd1, rv);
    total++; if (rv !== 8'h3C) $display("FAIL xor_R1: got %h expected 3c", rv); else passed++;
    total++; if (zero !== 1'b1) $display("FAIL xor_zero: got %b expected 1", zero); else passed++;
    din = 8'h00;
    run_for(4, 3);
    total++; if (zero !== 1'b1) $display("FAIL load_keeps_zero: got %b expected 1", zero); else passed++;
    run_for(5, 4);
    read_reg(3'd1, rv);
    total++; if (rv !== 8'h3C) $display("FAIL xor_nz_R1: got %h expected 3c", rv); else passed++;
    total++; if (zero !== 1'b0) $display("FAIL xor_nz_zero: got %b expected 0", zero); else passed++;
  endtask

  task automatic test_branch();
    do_reset();
    prog[0] = enc(4'd8, 3'd0, 3'd4);
    prog[1] = enc(4'd0, 3'd6, 3'd0);
    prog[2] = enc(4'd0, 3'd6, 3'd0);
    prog[3] = enc(4'd0, 3'd6, 3'd0);
    prog[4] = enc(4'd0, 3'd5, 3'd0);
    din = 8'h77;
    run_for(6, 5);
    total++; if (br_v !== 32'h4) $display("FAIL br_pulse: got %h expected 00000004", br_v); else passed++;
    total++; if (ba_seen !== 4'h4) $display("FAIL br_target: got %h expected 4", ba_seen); else passed++;
    total++; if (ba_bad !== 0) $display("FAIL br_ba_idle: got %0d nonzero cycles expected 0", ba_bad); else passed++;
    total++; if (done_v !== 32'h20) $display("FAIL br_done: got %h expected 00000020", done_v); else passed++;
    read_reg(3'd5, rv);
    total++; if (rv !== 8'h77) $display("FAIL br_target_exec_R5: got %h expected 77", rv); else passed++;
    read_reg(3'd6, rv);
    total++; if (rv !== 8'h00) $display("FAIL br_skipped_R6: got %h expected 00", rv); else passed++;
    total++; if (pc !== 4'd5) $display("FAIL br_pc: got %0d expected 5", pc); else passed++;
  endtask

  task automatic test_nop_na();
    do_reset();
    prog[0] = enc(4'd0, 3'd1, 3'd0);
    prog[1] = enc(4'd0, 3'd0, 3'd0);
    prog[2] = enc(4'd5, 3'd1, 3'd2);
    prog[3] = enc(4'd0, 3'd7, 3'd0);
    prog[4] = enc(4'd9, 3'd0, 3'd6);
    prog[5] = enc(4'd3, 3'd2, 3'd2);
    prog[6] = enc(4'd9, 3'd1, 3'd6);
    din = 8'h21;
    run_for(4, 3);
    din = 8'hAA;
    run_for(4, 3);
    total++; if (done_v !== 32'h8) $display("FAIL load_na_done: got %h expected 00000008", done_v); else passed++;
    run_for(4, 3);
    total++; if (done_v !== 32'h8) $display("FAIL nop_0101_done: got %h expected 00000008", done_v); else passed++;
    run_for(4, 3);
    total++; if (done_v !== 32'h8) $display("FAIL load_pc_done: got %h expected 00000008", done_v); else passed++;
    run_for(4, 3);
    total++; if (done_v !== 32'h8) $display("FAIL op1001_z0_done: got %h expected 00000008", done_v); else passed++;
    total++; if (br_v !== 32'h0) $display("FAIL op1001_z0_branch: got %h expected 0", br_v); else passed++;
    read_reg(3'd1, rv);
    total++; if (rv !== 8'h21) $display("FAIL nop_R1: got %h expected 21", rv); else passed++;
    for (int i = 2; i <= 7; i++) begin
      read_reg(3'(i), rv);
      total++; if (rv !== 8'h00) $display("FAIL nop_reg%0d: got %h expected 00", i, rv); else passed++;
    end
    read_reg(3'd0, rv);
    total++; if (rv !== 8'h00) $display("FAIL nop_na_read: got %h expected 00", rv); else passed++;
    run_for(5, 4);
    total++; if (zero !== 1'b1) $display("FAIL nop_xor_zero: got %b expected 1", zero); else passed++;
`ifdef EXEC_BRZ_EN
    run_for(3, 2);
    total++; if (br_v !== 32'h4) $display("FAIL brz_taken: got %h expected 00000004", br_v); else passed++;
    total++; if (ba_seen !== 4'hE) $display("FAIL brz_target: got %h expected e", ba_seen); else passed++;
    total++; if (done_v !== 32'h0) $display("FAIL brz_no_done: got %h expected 0", done_v); else passed++;
`else
    run_for(4, 3);
    total++; if (done_v !== 32'h8) $display("FAIL op1001_z1_done: got %h expected 00000008", done_v); else passed++;
    total++; if (br_v !== 32'h0) $display("FAIL op1001_z1_branch: got %h expected 0", br_v); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    prog[0] = enc(4'd0, 3'd3, 3'd0);
    prog[1] = enc(4'd8, 3'd0, 3'd4);
    prog[4] = enc(4'd3, 3'd3, 3'd3);
    prog[5] = enc(4'd0, 3'd4, 3'd0);
    din = 8'h09;
    run_for(13, 12);
    total++; if (done_v !== 32'h1208) $display("FAIL b2b_done: got %h expected 00001208", done_v); else passed++;
    total++; if (br_v !== 32'h20) $display("FAIL b2b_branch: got %h expected 00000020", br_v); else passed++;
    total++; if (ba_bad !== 0) $display("FAIL b2b_ba_idle: got %0d nonzero cycles expected 0", ba_bad); else passed++;
    read_reg(3'd3, rv);
    total++; if (rv !== 8'h00) $display("FAIL b2b_R3: got %h expected 00", rv); else passed++;
    read_reg(3'd4, rv);
    total++; if (rv !== 8'h09) $display("FAIL b2b_R4: got %h expected 09", rv); else passed++;
    total++; if (zero !== 1'b1) $display("FAIL b2b_zero: got %b expected 1", zero); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    prog[0] = enc(4'd0, 3'd1, 3'd0);
    prog[1] = enc(4'd2, 3'd1, 3'd1);
    din = 8'h11;
    run = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    total++; if (busy !== 1'b1) $display("FAIL mid_in_alu_busy: got %b expected 1", busy); else passed++;
    #2;
    rst = 1'b1;
    run = 1'b0;
    tick();
    total++; if (ifc.done !== 1'b0) $display("FAIL mid_no_done: got %b expected 0", ifc.done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else passed++;
    read_reg(3'd1, rv);
    total++; if (rv !== 8'h00) $display("FAIL mid_R1: got %h expected 00", rv); else passed++;
    rst = 1'b0;
    run_for(4, 3);
    total++; if (done_v !== 32'h8) $display("FAIL mid_restart_done: got %h expected 00000008", done_v); else passed++;
    read_reg(3'd1, rv);
    total++; if (rv !== 8'h11) $display("FAIL mid_restart_R1: got %h expected 11", rv); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 10'd0;
    test_reset();
    test_program();
    test_add_wrap();
    test_xor_zero();
    test_branch();
    test_nop_na();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
